// File: rtl/pc1.sv
// Next-PC datapath: registered p_in + INC, plus an optional sign-extended,
// word-scaled branch offset. p_out is the only state in the block.
module pc1 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] INC          = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] p_in,
  input  logic [15:0] instruct,
  input  logic        control,
  output logic [31:0] p_out
);

  logic [31:0] w_seq;
  logic [31:0] w_off;
  logic [31:0] w_nxt;
  logic [31:0] r_pc;

  assign w_seq = p_in + INC;
  // Word offset to byte offset: replicate the sign down to bit 18, then scale by 4.
  assign w_off = {{14{instruct[15]}}, instruct, 2'b00};
  assign w_nxt = control ? (w_seq + w_off) : w_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_nxt;
    end
  end

  assign p_out = r_pc;

endmodule

// File: tb/tb_pc1.sv
// Directed and randomized checks of pc1: expectations queued when inputs are
// driven, popped and compared one cycle later; reset checked asynchronously.
module tb_pc1;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] p_in;
  logic [15:0] instruct;
  logic        control;
  logic [31:0] p_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  pc1 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_in     (p_in),
    .instruct (instruct),
    .control  (control),
    .p_out    (p_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: widen to 64 bits, add signed word offset * 4, keep low 32 bits.
  function automatic logic [31:0] model(input logic [31:0] p, input logic [15:0] ins,
                                        input logic c);
    longint t;
    int     s;
    s = int'($signed(ins));
    t = longint'({32'd0, p}) + 64'sd4;
    if (c) t = t + longint'(s) * 4;
    return t[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] expv);
    total++;
    assert (p_out === expv)
    else begin
      bad++;
      $error("FAIL %s: p_out=%h expected=%h", tag, p_out, expv);
    end
    $display("check %s: p_out=%h expected=%h", tag, p_out, expv);
  endtask

  task automatic drive(input logic [31:0] p, input logic [15:0] ins, input logic c);
    p_in = p;
    instruct = ins;
    control = c;
    exp_q.push_back(model(p, ins, c));
  endtask

  // Drive at negedge, then compare one edge later.
  task automatic step(input string tag, input logic [31:0] p, input logic [15:0] ins,
                      input logic c);
    logic [31:0] e;
    @(negedge clk);
    drive(p, ins, c);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty, p_out=%h", tag, p_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, e);
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] e;
    rst_n = 1'b0;
    p_in = 32'd0;
    instruct = 16'd0;
    control = 1'b0;
    #1;
    check("reset_initial", RV);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", RV);

    @(negedge clk);
    rst_n = 1'b1;
    step("release_first", 32'd0, 16'd0, 1'b0);
    if (p_out !== 32'd4) ; // scoreboard already compared; constant cross-check below
    step("seq", 32'd104, 16'd100, 1'b0);
    step("branch_fwd", 32'd104, 16'd100, 1'b1);
    total++;
    assert (p_out === 32'd508)
    else begin
      bad++;
      $error("FAIL branch_fwd_const: p_out=%h expected=%h", p_out, 32'd508);
    end

    // Async reset between edges, 508 is pending loss.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", RV);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_edge", RV);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step("release_seq", 32'd0, 16'd0, 1'b0);

    step("neg_one", 32'd104, 16'hFFFF, 1'b1);
    step("neg_min", 32'd104, 16'h8000, 1'b1);
    total++;
    assert (p_out === 32'hFFFE_006C)
    else begin
      bad++;
      $error("FAIL neg_min_const: p_out=%h expected=%h", p_out, 32'hFFFE_006C);
    end
    step("wrap_seq", 32'hFFFF_FFFC, 16'h1234, 1'b0);
    step("wrap_branch", 32'hFFFF_FFF8, 16'd2, 1'b1);
    step("unaligned", 32'h0000_1003, 16'hFFFE, 1'b1);
    step("ignore_instr", 32'h0000_2001, 16'h7FFF, 1'b0);
    step("max_pos", 32'h0000_0000, 16'h7FFF, 1'b1);

    // Hold: inputs changed between edges must not reach p_out early.
    @(negedge clk);
    held = p_out;
    p_in = 32'd104;
    instruct = 16'd100;
    control = 1'b0;
    #1;
    check("hold_a", held);
    p_in = 32'd200;
    control = 1'b1;
    #1;
    check("hold_b", held);
    exp_q.push_back(model(32'd200, 16'd100, 1'b1));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("hold_edge", e);

    for (int i = 0; i < 20; i++) begin
      step("random", $urandom, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
